// File: rtl/delay_line_prog.sv
// delay_line_prog
//   Multi-channel programmable delay line. Each channel delays a SIZE-bit
//   word plus its valid flag by 0..MAX_DELAY enabled clock cycles using a
//   per-channel circular buffer. After a delay change, valid_out is masked
//   for (new delay - 1) enabled cycles so stale buffer entries are never
//   flagged valid.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         advance enable; low freezes all state
//   delay_sel  per-channel delay select, channel c at [c*DLY_W +: DLY_W]
//   data_in    per-channel input word, channel c at [c*SIZE +: SIZE]
//   valid_in   per-channel input valid
//   data_out   per-channel delayed word
//   valid_out  per-channel delayed valid, masked while settling
//   settling   per-channel flag, high while stale entries are suppressed
module delay_line_prog #(
  parameter int SIZE      = 8,
  parameter int CHANNELS  = 2,
  parameter int MAX_DELAY = 16,
  // Derived width of one delay-select field; not meant to be overridden.
  parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CHANNELS*DLY_W-1:0] delay_sel,
  input  logic [CHANNELS*SIZE-1:0]  data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS*SIZE-1:0]  data_out,
  output logic [CHANNELS-1:0]       valid_out,
  output logic [CHANNELS-1:0]       settling
);

  localparam int          PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int          AW    = DLY_W + 1;
  localparam int unsigned DEPTH = MAX_DELAY;

  typedef logic [SIZE:0] entry_t;

  // Shared write pointer: every channel writes the same slot each enabled edge.
  logic [PTR_W-1:0] wptr_q, wptr_d;

  always_comb begin
    wptr_d = wptr_q;
    if (en) begin
      // Depth need not be a power of two, so wrap explicitly.
      if (wptr_q == PTR_W'(MAX_DELAY - 1)) wptr_d = '0;
      else                                 wptr_d = wptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wptr_q <= '0;
    else        wptr_q <= wptr_d;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DLY_W-1:0] sel, eff;
    logic [DLY_W-1:0] dq_q, dq_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    w_ext, d_ext;
    logic [PTR_W-1:0] rd_idx;
    entry_t           mem_q [MAX_DELAY];
    entry_t           rd;
    logic             settle;
    logic             v;
    logic [SIZE-1:0]  d;

    assign sel = delay_sel[c*DLY_W +: DLY_W];
    assign eff = (sel > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : sel;

    // A new delay reloads the settle counter (latest change wins); otherwise
    // the counter runs down to zero.
    always_comb begin
      dq_d  = dq_q;
      cnt_d = cnt_q;
      if (en) begin
        if (eff != dq_q) begin
          dq_d  = eff;
          cnt_d = (eff == '0) ? '0 : eff - DLY_W'(1);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dq_q  <= '0;
        cnt_q <= '0;
      end else begin
        dq_q  <= dq_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (en) begin
        mem_q[wptr_q] <= {valid_in[c], data_in[c*SIZE +: SIZE]};
      end
    end

    // Read slot (wptr - dq) mod MAX_DELAY; with dq == MAX_DELAY this is the
    // slot about to be overwritten, which still holds the old entry.
    assign w_ext  = AW'(wptr_q);
    assign d_ext  = AW'(dq_q);
    assign rd_idx = (w_ext >= d_ext) ? PTR_W'(w_ext - d_ext)
                                     : PTR_W'(w_ext + AW'(MAX_DELAY) - d_ext);
    assign rd     = mem_q[rd_idx];

    always_comb begin
      settle = (cnt_q != '0);
      if (dq_q == '0) begin
        v = valid_in[c];
        d = data_in[c*SIZE +: SIZE];
      end else begin
        v = rd[SIZE];
        d = rd[SIZE-1:0];
      end
    end

    // dq resets to 0 (bypass), so the outputs are forced low while reset is
    // held; the bypass only shows data_in once rst_n is released.
    assign data_out[c*SIZE +: SIZE] = rst_n ? d : '0;
    assign valid_out[c]             = rst_n & v & ~settle;
    assign settling[c]              = settle;
  end

endmodule

// File: tb/tb_delay_line_prog.sv
// tb_delay_line_prog
//   Bench for delay_line_prog. A reference model keeps the full history of
//   enabled-cycle inputs per channel and derives each output as the input
//   recorded dq enabled cycles earlier; directed sections pin literal values
//   and a long randomized phase exercises delay changes, freezes and resets.
module tb_delay_line_prog;

  localparam int SZ = 8;
  localparam int CH = 2;
  localparam int MD = 16;
  localparam int DW = 5;
  localparam int HN = 4096;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CH*DW-1:0] delay_sel;
  logic [CH*SZ-1:0] data_in;
  logic [CH-1:0]    valid_in;
  logic [CH*SZ-1:0] data_out;
  logic [CH-1:0]    valid_out;
  logic [CH-1:0]    settling;

  delay_line_prog #(
    .SIZE(SZ),
    .CHANNELS(CH),
    .MAX_DELAY(MD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .delay_sel(delay_sel),
    .data_in(data_in),
    .valid_in(valid_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .settling(settling)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k counts enabled edges since reset; hist[c][i] is the
  // {valid,data} pair captured at enabled edge i. m_dq is the active delay and
  // m_sup the number of further enabled cycles valid_out stays suppressed.
  int          k = 0;
  int          m_dq  [CH] = '{0, 0};
  int          m_sup [CH] = '{0, 0};
  logic [SZ:0] hist  [CH][HN];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0;
        for (int c = 0; c < CH; c++) begin
          m_dq[c]  = 0;
          m_sup[c] = 0;
        end
      end else if (en) begin
        for (int c = 0; c < CH; c++) begin
          int e;
          e = int'(delay_sel[c*DW +: DW]);
          if (e > MD) e = MD;
          if (k < HN) hist[c][k] = {valid_in[c], data_in[c*SZ +: SZ]};
          if (e != m_dq[c]) begin
            m_dq[c]  = e;
            m_sup[c] = (e == 0) ? 0 : e - 1;
          end else if (m_sup[c] > 0) begin
            m_sup[c] = m_sup[c] - 1;
          end
        end
        k++;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_valid_out", valid_out, 0);
        chk("reset_settling", settling, 0);
        chk("reset_data_out", data_out, 0);
      end else begin
        for (int c = 0; c < CH; c++) begin
          logic          v, ev;
          logic [SZ-1:0] d;
          int            idx;
          if (m_dq[c] == 0) begin
            v = valid_in[c];
            d = data_in[c*SZ +: SZ];
          end else begin
            idx = k - m_dq[c];
            if (idx < 0 || idx >= HN) begin
              v = 1'b0;
              d = '0;
            end else begin
              v = hist[c][idx][SZ];
              d = hist[c][idx][SZ-1:0];
            end
          end
          ev = v && (m_sup[c] == 0);
          chk($sformatf("valid_out[%0d]", c), valid_out[c], ev);
          chk($sformatf("settling[%0d]", c), settling[c], m_sup[c] != 0);
          if (m_dq[c] == 0 || ev)
            chk($sformatf("data_out[%0d]", c), data_out[c*SZ +: SZ], d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int c, input int v);
    delay_sel[c*DW +: DW] = DW'(v);
  endtask

  task automatic set_d(input int c, input int v);
    data_in[c*SZ +: SZ] = SZ'(v);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    delay_sel = '0;
    data_in   = 16'h2010;
    valid_in  = 2'b11;
    set_sel(0, 3);
    set_sel(1, 5);
    #2;
    chk("lit_reset_valid", valid_out, 0);
    chk("lit_reset_settling", settling, 0);
    chk("lit_reset_data", data_out, 0);

    // Startup at delays 3 / 5, counting streams 0x10.. and 0x20..
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) chk("lit_settle_e1", settling, 2'b11);
      if (j == 2) begin
        chk("lit_settle_e2", settling, 2'b11);
        chk("lit_valid_e2", valid_out, 2'b00);
      end
      if (j == 3) begin
        chk("lit_settle_e3", settling, 2'b10);
        chk("lit_ch0_first", data_out[7:0], 8'h10);
        chk("lit_ch0_first_v", valid_out[0], 1'b1);
      end
      if (j == 4) chk("lit_ch1_settle_e4", settling[1], 1'b1);
      if (j == 5) begin
        chk("lit_settle_e5", settling, 2'b00);
        chk("lit_ch1_first", data_out[15:8], 8'h20);
        chk("lit_ch1_first_v", valid_out[1], 1'b1);
      end
      set_d(0, 'h10 + j);
      set_d(1, 'h20 + j);
    end

    // Bypass: delay 0 is zero-latency.
    set_sel(0, 0);
    tick();
    set_d(0, 'hC3);
    valid_in[0] = 1'b1;
    #1;
    chk("lit_bypass_data", data_out[7:0], 8'hC3);
    chk("lit_bypass_v1", valid_out[0], 1'b1);
    valid_in[0] = 1'b0;
    set_d(0, 'h3C);
    #1;
    chk("lit_bypass_v0", valid_out[0], 1'b0);
    chk("lit_bypass_data2", data_out[7:0], 8'h3C);

    // Over-range select clamps to MAX_DELAY; stream across pointer wrap.
    set_sel(0, 20);
    tick();
    set_d(0, 'hA0);
    valid_in[0] = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (j == 14) chk("lit_clamp_settling", settling[0], 1'b1);
      if (j == 15) chk("lit_clamp_pre", valid_out[0], 1'b0);
      if (j == 16) begin
        chk("lit_clamp_first", data_out[7:0], 8'hA0);
        chk("lit_clamp_first_v", valid_out[0], 1'b1);
      end
      set_d(0, 'hA0 + j);
    end

    // Delay 4 then 2 mid-stream.
    set_sel(0, 4);
    set_d(0, 'h30);
    tick();
    for (int i = 1; i <= 7; i++) begin
      set_d(0, 'h30 + i);
      tick();
    end
    set_d(0, 'h38);
    set_sel(0, 2);
    tick();
    chk("lit_switch_gap", valid_out[0], 1'b0);
    chk("lit_switch_settle", settling[0], 1'b1);
    set_d(0, 'h39);
    tick();
    chk("lit_switch_next", data_out[7:0], 8'h38);
    chk("lit_switch_next_v", valid_out[0], 1'b1);
    set_d(0, 'h3A);
    tick();
    chk("lit_switch_next2", data_out[7:0], 8'h39);

    // Freeze with en low after two words at delay 3.
    set_sel(0, 3);
    valid_in[0] = 1'b0;
    tick();
    tick();
    tick();
    valid_in[0] = 1'b1;
    set_d(0, 'h01);
    tick();
    set_d(0, 'h02);
    tick();
    valid_in[0] = 1'b0;
    set_d(0, 'h00);
    en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("lit_freeze_v", valid_out[0], 1'b0);
    end
    en = 1'b1;
    tick();
    chk("lit_resume_1", data_out[7:0], 8'h01);
    chk("lit_resume_1v", valid_out[0], 1'b1);
    tick();
    chk("lit_resume_2", data_out[7:0], 8'h02);
    chk("lit_resume_2v", valid_out[0], 1'b1);
    tick();
    chk("lit_resume_end", valid_out[0], 1'b0);

    // Reset mid-stream at delay 4.
    set_sel(0, 4);
    valid_in[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_d(0, 'h50 + i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("lit_midrst_valid", valid_out, 0);
    chk("lit_midrst_settle", settling, 0);
    tick();
    rst_n = 1'b1;
    set_d(0, 'h77);
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j == 3) chk("lit_postrst_pre", valid_out[0], 1'b0);
      if (j == 4) begin
        chk("lit_postrst_first", data_out[7:0], 8'h77);
        chk("lit_postrst_first_v", valid_out[0], 1'b1);
      end
      set_d(0, 'h77 + j);
    end

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      tick();
      valid_in = CH'($urandom);
      data_in  = (CH*SZ)'($urandom);
      en       = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 24) == 0) set_sel(c, int'($urandom_range(0, 31)));
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
